i3c_pattern_detector: RTL and testbench

I3C_PATTERN_DETECTOR -- requirements
Module: i3c_pattern_detector

---
 rtl/i3c_pattern_detector_if.sv | 26 ++
 rtl/i3c_pattern_detector.sv | 120 ++++++++++++
 tb/tb_i3c_pattern_detector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/i3c_pattern_detector_if.sv
// Side-band control and status bundle between an I3C target front end and its
// SDA/SCL pattern detector. Clocks and resets are kept off this bundle.
interface i3c_pattern_detector_if #(
  parameter int CNT_W = 4
);
  logic             pin_SCL_in;
  logic             in_HDR_mode;
  logic             HDR_restart_ack;
  logic             tgt_rst_ack;
  logic             scan_no_rst;
  logic [CNT_W-1:0] oFall_cnt;
  logic             oHDR_exit;
  logic             oHDR_restart;
  logic             oTgtRst_pend;
  logic             oTgtRst;

  modport master (
    output pin_SCL_in, in_HDR_mode, HDR_restart_ack, tgt_rst_ack, scan_no_rst,
    input  oFall_cnt, oHDR_exit, oHDR_restart, oTgtRst_pend, oTgtRst
  );

  modport slave (
    input  pin_SCL_in, in_HDR_mode, HDR_restart_ack, tgt_rst_ack, scan_no_rst,
    output oFall_cnt, oHDR_exit, oHDR_restart, oTgtRst_pend, oTgtRst
  );
endinterface

// File: rtl/i3c_pattern_detector.sv
// Counts SDA falls while SCL is low to spot HDR exit/restart patterns and the
// target-reset pattern (RST_FALLS falls, Sr, P), using SDA/SCL edges as clocks.
module i3c_pattern_detector #(
  parameter logic [2:0] ENA_HDR     = 3'b000,
  parameter int         ENA_TGT_RST = 1,
  parameter int         CNT_W       = 4,
  parameter int         EXIT_FALLS  = 4,
  parameter int         RST_FALLS   = 7
) (
  input  logic                   clk_SDA_n,
  input  logic                   scl_rst_n,
  input  logic                   clk_SDA,
  input  logic                   clk_SCL,
  input  logic                   RSTn,
  i3c_pattern_detector_if.slave  bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  localparam logic [CNT_W-1:0] EXIT_CNT    = CNT_W'(EXIT_FALLS);
  localparam logic [CNT_W-1:0] RESTART_CNT = CNT_W'(EXIT_FALLS - 2);
  localparam logic [CNT_W-1:0] RST_CNT     = CNT_W'(RST_FALLS);

  // The parent already folds RSTn into scl_rst_n; it is repeated here so the
  // counter clears on a global reset even while scan_no_rst masks SCL.
  logic             cnt_rst_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_rst_n = scl_rst_n & RSTn;

  always_comb begin
    cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk_SDA_n or negedge cnt_rst_n) begin
    if (!cnt_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign bus.oFall_cnt = cnt_q;
  assign bus.oHDR_exit = (cnt_q >= EXIT_CNT);

  generate
    if (ENA_HDR != 3'b000) begin : g_restart
      logic restart_rst_n;
      logic poss_restart_q, poss_restart_d;
      logic is_restart_q, is_restart_d;

      assign restart_rst_n = RSTn &
        ((~bus.HDR_restart_ack & bus.in_HDR_mode) | bus.scan_no_rst);

      always_comb begin
        poss_restart_d = (cnt_q == RESTART_CNT);
        is_restart_d   = poss_restart_q;
      end

      // Restart = SDA rises after EXIT_FALLS-2 falls, then SCL rises.
      always_ff @(posedge clk_SDA or negedge restart_rst_n) begin
        if (!restart_rst_n) poss_restart_q <= 1'b0;
        else                poss_restart_q <= poss_restart_d;
      end

      always_ff @(posedge clk_SCL or negedge restart_rst_n) begin
        if (!restart_rst_n) is_restart_q <= 1'b0;
        else                is_restart_q <= is_restart_d;
      end

      assign bus.oHDR_restart = is_restart_q;
    end else begin : g_no_restart
      logic unused_restart;
      assign unused_restart   = ^{bus.in_HDR_mode, bus.HDR_restart_ack};
      assign bus.oHDR_restart = 1'b0;
    end
  endgenerate

  generate
    if (ENA_TGT_RST != 0) begin : g_tgt_rst
      logic tr_rst_n;
      logic armed_q, armed_d;
      logic sr_seen_q, sr_seen_d;
      logic done_q, done_d;

      assign tr_rst_n = RSTn & (~bus.tgt_rst_ack | bus.scan_no_rst);

      always_comb begin
        armed_d   = (cnt_q == RST_CNT);
        sr_seen_d = armed_q & bus.pin_SCL_in;
        done_d    = done_q | (sr_seen_q & bus.pin_SCL_in);
      end

      // armed is resampled at every SCL rise, so an overlong fall run disarms.
      always_ff @(posedge clk_SCL or negedge tr_rst_n) begin
        if (!tr_rst_n) armed_q <= 1'b0;
        else           armed_q <= armed_d;
      end

      always_ff @(posedge clk_SDA_n or negedge tr_rst_n) begin
        if (!tr_rst_n) sr_seen_q <= 1'b0;
        else           sr_seen_q <= sr_seen_d;
      end

      always_ff @(posedge clk_SDA or negedge tr_rst_n) begin
        if (!tr_rst_n) done_q <= 1'b0;
        else           done_q <= done_d;
      end

      assign bus.oTgtRst      = done_q;
      assign bus.oTgtRst_pend = (armed_q | sr_seen_q) & ~done_q;
    end else begin : g_no_tgt_rst
      logic unused_tgt_rst;
      assign unused_tgt_rst   = ^{bus.tgt_rst_ack, bus.pin_SCL_in, clk_SCL, clk_SDA};
      assign bus.oTgtRst      = 1'b0;
      assign bus.oTgtRst_pend = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_i3c_pattern_detector.sv
// Directed bench for i3c_pattern_detector: drives SDA/SCL as bus levels and
// checks counter, HDR exit/restart and target-reset outputs against hand values.
module tb_i3c_pattern_detector;
  logic sda;
  logic scl;
  logic RSTn;
  logic clk_SDA_n;
  logic clk_SDA;
  logic clk_SCL;
  logic scl_rst_n;
  int   checks;
  int   errors;

  i3c_pattern_detector_if #(.CNT_W(4)) bus ();

  assign clk_SDA        = sda;
  assign clk_SDA_n      = ~sda;
  assign clk_SCL        = scl;
  assign bus.pin_SCL_in = scl;
  assign scl_rst_n      = RSTn & (~scl | bus.scan_no_rst);

  i3c_pattern_detector #(
    .ENA_HDR     (3'b001),
    .ENA_TGT_RST (1),
    .CNT_W       (4),
    .EXIT_FALLS  (4),
    .RST_FALLS   (7)
  ) dut (
    .clk_SDA_n (clk_SDA_n),
    .scl_rst_n (scl_rst_n),
    .clk_SDA   (clk_SDA),
    .clk_SCL   (clk_SCL),
    .RSTn      (RSTn),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sda_lo(); sda = 1'b0; #5; endtask
  task automatic sda_hi(); sda = 1'b1; #5; endtask
  task automatic scl_lo(); scl = 1'b0; #5; endtask
  task automatic scl_hi(); scl = 1'b1; #5; endtask

  task automatic falls(input int n);
    for (int i = 0; i < n; i++) begin
      sda_lo();
      sda_hi();
    end
  endtask

  // n falls with SCL low, SCL rise, Sr, SCL low/high, P
  task automatic tr_seq(input string tag, input int n, input logic exp_arm);
    scl_lo();
    falls(n);
    scl_hi();
    chk({tag, "_pend_arm"}, 32'(bus.oTgtRst_pend), 32'(exp_arm));
    sda_lo();
    chk({tag, "_pend_sr"}, 32'(bus.oTgtRst_pend), 32'(exp_arm));
    scl_lo();
    scl_hi();
    chk({tag, "_pend_pre_p"}, 32'(bus.oTgtRst_pend), 32'(exp_arm));
    sda_hi();
    chk({tag, "_tgtrst"}, 32'(bus.oTgtRst), 32'(exp_arm));
    chk({tag, "_pend_end"}, 32'(bus.oTgtRst_pend), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sda = 1'b1;
    scl = 1'b1;
    RSTn = 1'b1;
    bus.in_HDR_mode = 1'b0;
    bus.HDR_restart_ack = 1'b0;
    bus.tgt_rst_ack = 1'b0;
    bus.scan_no_rst = 1'b0;
    #1;
    RSTn = 1'b0;
    #5;
    chk("rst_cnt",     32'(bus.oFall_cnt),    32'd0);
    chk("rst_exit",    32'(bus.oHDR_exit),    32'd0);
    chk("rst_restart", 32'(bus.oHDR_restart), 32'd0);
    chk("rst_pend",    32'(bus.oTgtRst_pend), 32'd0);
    chk("rst_tgtrst",  32'(bus.oTgtRst),      32'd0);
    RSTn = 1'b1;
    #5;

    // HDR exit after 4 falls, cleared asynchronously by SCL high
    scl_lo();
    falls(3);
    chk("exit_3falls", 32'(bus.oHDR_exit), 32'd0);
    sda_lo();
    chk("exit_4falls", 32'(bus.oHDR_exit), 32'd1);
    chk("cnt_4falls",  32'(bus.oFall_cnt), 32'd4);
    sda_hi();
    scl_hi();
    chk("exit_scl_hi", 32'(bus.oHDR_exit), 32'd0);
    chk("cnt_scl_hi",  32'(bus.oFall_cnt), 32'd0);
    chk("pend_4falls", 32'(bus.oTgtRst_pend), 32'd0);

    // 3 falls never exit; 16 falls saturate
    scl_lo();
    falls(3);
    chk("cnt_3falls",   32'(bus.oFall_cnt), 32'd3);
    chk("exit_3only",   32'(bus.oHDR_exit), 32'd0);
    scl_hi();
    chk("exit_3_sclhi", 32'(bus.oHDR_exit), 32'd0);
    scl_lo();
    falls(16);
    chk("cnt_sat",  32'(bus.oFall_cnt), 32'd15);
    chk("exit_sat", 32'(bus.oHDR_exit), 32'd1);
    scl_hi();
    chk("cnt_sat_clr", 32'(bus.oFall_cnt), 32'd0);

    // HDR restart
    bus.in_HDR_mode = 1'b1;
    #5;
    scl_lo();
    falls(2);
    chk("restart_pre_scl", 32'(bus.oHDR_restart), 32'd0);
    scl_hi();
    chk("restart_set", 32'(bus.oHDR_restart), 32'd1);
    bus.HDR_restart_ack = 1'b1;
    #5;
    chk("restart_ack", 32'(bus.oHDR_restart), 32'd0);
    bus.HDR_restart_ack = 1'b0;
    #5;
    chk("restart_ack_rel", 32'(bus.oHDR_restart), 32'd0);
    bus.in_HDR_mode = 1'b0;
    #5;
    scl_lo();
    falls(2);
    scl_hi();
    chk("restart_no_mode", 32'(bus.oHDR_restart), 32'd0);

    // Target reset: good pattern, sticky, then acknowledged
    tr_seq("tr7", 7, 1'b1);
    scl_lo();
    scl_hi();
    chk("tr7_sticky", 32'(bus.oTgtRst), 32'd1);
    bus.tgt_rst_ack = 1'b1;
    #5;
    chk("tr7_ack",      32'(bus.oTgtRst),      32'd0);
    chk("tr7_ack_pend", 32'(bus.oTgtRst_pend), 32'd0);
    bus.tgt_rst_ack = 1'b0;
    #5;

    tr_seq("tr8", 8, 1'b0);
    tr_seq("tr6", 6, 1'b0);

    // RSTn pulse after Sr aborts the pattern
    scl_lo();
    falls(7);
    scl_hi();
    chk("abort_pend_arm", 32'(bus.oTgtRst_pend), 32'd1);
    sda_lo();
    chk("abort_pend_sr", 32'(bus.oTgtRst_pend), 32'd1);
    RSTn = 1'b0;
    #5;
    chk("abort_pend_rst", 32'(bus.oTgtRst_pend), 32'd0);
    RSTn = 1'b1;
    #5;
    scl_lo();
    scl_hi();
    sda_hi();
    chk("abort_tgtrst", 32'(bus.oTgtRst),      32'd0);
    chk("abort_pend",   32'(bus.oTgtRst_pend), 32'd0);

    // scan_no_rst masks the SCL term but not RSTn
    bus.scan_no_rst = 1'b1;
    #5;
    sda_lo();
    chk("scan_cnt1", 32'(bus.oFall_cnt), 32'd1);
    sda_hi();
    sda_lo();
    chk("scan_cnt2", 32'(bus.oFall_cnt), 32'd2);
    RSTn = 1'b0;
    #5;
    chk("scan_rstn", 32'(bus.oFall_cnt), 32'd0);
    RSTn = 1'b1;
    sda_hi();
    bus.scan_no_rst = 1'b0;
    #5;
    chk("scan_off_cnt", 32'(bus.oFall_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
